// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and constants for the 4x4 sequential multiplier
package mul_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        PP3  = 3'd4,
        DONE = 3'd5
    } state_e;

    localparam int          OPW  = 4;
    localparam int          PW   = 8;
    localparam int          ACCW = 10;
    localparam logic [PW-1:0] SAT = 8'hFF;

    // Left shift applied to each pass's partial product before accumulation.
    function automatic logic [2:0] pass_shift(input state_e s);
        case (s)
            PP1, PP2: return 3'd2;
            PP3:      return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mul2x2_core.sv
// rtl/mul2x2_core.sv - exact 2x2-bit multiplier core, port-compatible with approximate netlists
module mul2x2_core (
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3
);

    logic [3:0] p;

    assign p = {2'b00, in1, in0} * {2'b00, in3, in2};
    assign {out3, out2, out1, out0} = p;

endmodule

// File: rtl/mul4x4_seq_ctrl.sv
// rtl/mul4x4_seq_ctrl.sv - 4x4 unsigned multiply via four passes through one 2x2 core
import mul_seq_pkg::*;

module mul4x4_seq_ctrl #(
    parameter bit ZERO_SKIP     = 1'b1,
    parameter bit CORE_ALL_ONES = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] product,
    output logic       ovf,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    state_e             state_q, state_d;
    logic [OPW-1:0]     a_q, a_d, b_q, b_d;
    logic [ACCW-1:0]    acc_q, acc_d, acc_sum, pp_shifted;
    logic [PW-1:0]      product_q, product_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [1:0]         core_x, core_y;
    logic [3:0]         exact_p, core_p;
    logic               accept, skip, sum_ovf;

    assign accept = in_valid && (state_q == IDLE);
    assign skip   = ZERO_SKIP && ((a == '0) || (b == '0));

    always_comb begin
        core_x = 2'b00;
        core_y = 2'b00;
        case (state_q)
            PP0: begin core_x = a_q[1:0]; core_y = b_q[1:0]; end
            PP1: begin core_x = a_q[3:2]; core_y = b_q[1:0]; end
            PP2: begin core_x = a_q[1:0]; core_y = b_q[3:2]; end
            PP3: begin core_x = a_q[3:2]; core_y = b_q[3:2]; end
            default: ;
        endcase
    end

    mul2x2_core u_core (
        .in0  (core_x[0]),
        .in1  (core_x[1]),
        .in2  (core_y[0]),
        .in3  (core_y[1]),
        .out0 (exact_p[0]),
        .out1 (exact_p[1]),
        .out2 (exact_p[2]),
        .out3 (exact_p[3])
    );

    // Saturation probe: a constant all-ones core drives the accumulator to its maximum.
    assign core_p     = CORE_ALL_ONES ? 4'hF : exact_p;
    assign pp_shifted = ACCW'(core_p) << pass_shift(state_q);
    assign acc_sum    = acc_q + pp_shifted;
    assign sum_ovf    = acc_sum > ACCW'(SAT);

    // out_valid trails DONE entry by one cycle, so the result is presented
    // from a settled register and DONE always lasts at least two cycles.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        product_d   = product_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d   = a;
                    b_d   = b;
                    acc_d = '0;
                    if (skip) begin
                        state_d   = DONE;
                        product_d = '0;
                        ovf_d     = 1'b0;
                    end else begin
                        state_d = PP0;
                    end
                end
            end
            PP0: begin acc_d = acc_sum; state_d = PP1; end
            PP1: begin acc_d = acc_sum; state_d = PP2; end
            PP2: begin acc_d = acc_sum; state_d = PP3; end
            PP3: begin
                acc_d     = acc_sum;
                state_d   = DONE;
                ovf_d     = sum_ovf;
                product_d = sum_ovf ? SAT : acc_sum[PW-1:0];
            end
            DONE: begin
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mul4x4_seq_ctrl.sv
// tb/tb_mul4x4_seq_ctrl.sv - self-checking bench for mul4x4_seq_ctrl
module tb_mul4x4_seq_ctrl;

    // Instance 0: exact core, zero-skip on. 1: exact core, zero-skip off. 2: all-ones core.
    logic       clk;
    logic       rst_n;
    logic [3:0] a_s   [3];
    logic [3:0] b_s   [3];
    logic       iv_s  [3];
    logic       ir_s  [3];
    logic [7:0] pr_s  [3];
    logic       of_s  [3];
    logic       ov_s  [3];
    logic       ordy_s[3];
    logic       busy_s[3];

    int errors = 0;
    int checks = 0;

    mul4x4_seq_ctrl #(.ZERO_SKIP(1'b1), .CORE_ALL_ONES(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a_s[0]), .b(b_s[0]), .in_valid(iv_s[0]),
        .in_ready(ir_s[0]), .product(pr_s[0]), .ovf(of_s[0]), .out_valid(ov_s[0]),
        .out_ready(ordy_s[0]), .busy(busy_s[0]));
    mul4x4_seq_ctrl #(.ZERO_SKIP(1'b0), .CORE_ALL_ONES(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a_s[1]), .b(b_s[1]), .in_valid(iv_s[1]),
        .in_ready(ir_s[1]), .product(pr_s[1]), .ovf(of_s[1]), .out_valid(ov_s[1]),
        .out_ready(ordy_s[1]), .busy(busy_s[1]));
    mul4x4_seq_ctrl #(.ZERO_SKIP(1'b1), .CORE_ALL_ONES(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a_s[2]), .b(b_s[2]), .in_valid(iv_s[2]),
        .in_ready(ir_s[2]), .product(pr_s[2]), .ovf(of_s[2]), .out_valid(ov_s[2]),
        .out_ready(ordy_s[2]), .busy(busy_s[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;
        logic [3:0] a;
        logic [3:0] b;
        int         hold;
        logic [7:0] exp_p;
        logic       exp_ovf;
        int         exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: product from plain arithmetic; the all-ones core contributes 15 per pass
    // weighted 1,4,4,16.
    task automatic model(input int d, input int av, input int bv,
                         output logic [7:0] p, output logic o, output int lat);
        int sum;
        bit zs;
        zs = (d != 1);
        if (zs && (av == 0 || bv == 0)) begin
            p = 8'd0; o = 1'b0; lat = 1;
        end else begin
            sum = (d == 2) ? 15 * (1 + 4 + 4 + 16) : av * bv;
            o   = (sum > 255);
            p   = o ? 8'hFF : 8'(sum);
            lat = 5;
        end
    endtask

    task automatic run_op(input int d, input logic [3:0] av, input logic [3:0] bv,
                          input int hold, output logic [7:0] pr, output logic o,
                          output int lat);
        logic [7:0] p0;
        logic       o0;
        @(posedge clk); #1;
        chk("in_ready_before_accept", ir_s[d], 1'b1);
        a_s[d] = av; b_s[d] = bv; iv_s[d] = 1'b1; ordy_s[d] = 1'b0;
        @(posedge clk); #1;
        iv_s[d] = 1'b0;
        lat = 0;
        while (!ov_s[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        pr = pr_s[d];
        o  = of_s[d];
        p0 = pr; o0 = o;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_product_stable", pr_s[d], p0);
            chk("hold_ovf_stable", of_s[d], o0);
            chk("hold_out_valid", ov_s[d], 1'b1);
            chk("hold_in_ready_low", ir_s[d], 1'b0);
        end
        ordy_s[d] = 1'b1;
        @(posedge clk); #1;
        ordy_s[d] = 1'b0;
        chk("in_ready_after_consume", ir_s[d], 1'b1);
        chk("out_valid_after_consume", ov_s[d], 1'b0);
    endtask

    task automatic apply(input vec_t v);
        logic [7:0] p;
        logic       o;
        int         lat;
        run_op(v.d, v.a, v.b, v.hold, p, o, lat);
        chk($sformatf("lat d%0d %0d*%0d", v.d, v.a, v.b), lat, v.exp_lat);
        chk($sformatf("product d%0d %0d*%0d", v.d, v.a, v.b), p, v.exp_p);
        chk($sformatf("ovf d%0d %0d*%0d", v.d, v.a, v.b), o, v.exp_ovf);
    endtask

    initial begin
        logic [7:0] p;
        logic       o;
        int         lat;
        vec_t       v;
        logic [7:0] got[$];
        logic       pre_ir, pre_ov;
        logic [7:0] pre_pr;
        int         accepts;
        int         quiet_viol;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_s[i] = '0; b_s[i] = '0; iv_s[i] = 1'b0; ordy_s[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("reset_in_ready", ir_s[i], 1'b1);
            chk("reset_out_valid", ov_s[i], 1'b0);
            chk("reset_busy", busy_s[i], 1'b0);
            chk("reset_product", pr_s[i], 8'd0);
            chk("reset_ovf", of_s[i], 1'b0);
        end
        #3 rst_n = 1'b1;

        vecs.push_back('{0, 4'd13, 4'd11, 0, 8'd143,  1'b0, 5});
        vecs.push_back('{0, 4'd0,  4'd9,  0, 8'd0,    1'b0, 1});
        vecs.push_back('{1, 4'd0,  4'd9,  0, 8'd0,    1'b0, 5});
        vecs.push_back('{0, 4'd15, 4'd15, 3, 8'd225,  1'b0, 5});
        vecs.push_back('{2, 4'd15, 4'd15, 0, 8'hFF,   1'b1, 5});
        vecs.push_back('{2, 4'd1,  4'd1,  1, 8'hFF,   1'b1, 5});
        vecs.push_back('{2, 4'd0,  4'd5,  0, 8'd0,    1'b0, 1});
        vecs.push_back('{1, 4'd15, 4'd0,  0, 8'd0,    1'b0, 5});
        vecs.push_back('{1, 4'd10, 4'd12, 2, 8'd120,  1'b0, 5});
        vecs.push_back('{0, 4'd5,  4'd0,  0, 8'd0,    1'b0, 1});
        foreach (vecs[i]) apply(vecs[i]);

        // Reset mid-operation, during PP2.
        @(posedge clk); #1;
        a_s[0] = 4'd13; b_s[0] = 4'd11; iv_s[0] = 1'b1;
        @(posedge clk); #1;
        iv_s[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_in_ready", ir_s[0], 1'b1);
        chk("midreset_busy", busy_s[0], 1'b0);
        chk("midreset_out_valid", ov_s[0], 1'b0);
        chk("midreset_product", pr_s[0], 8'd0);
        chk("midreset_ovf", of_s[0], 1'b0);
        #3 rst_n = 1'b1;
        quiet_viol = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ov_s[0] || busy_s[0]) quiet_viol++;
        end
        chk("aborted_op_silent", quiet_viol, 0);
        run_op(0, 4'd3, 4'd3, 0, p, o, lat);
        chk("post_reset_product", p, 8'd9);
        chk("post_reset_lat", lat, 5);

        // Back-to-back with in_valid held high through the first operation.
        @(posedge clk); #1;
        a_s[0] = 4'd6; b_s[0] = 4'd7; iv_s[0] = 1'b1; ordy_s[0] = 1'b1;
        accepts = 0;
        pre_ir = ir_s[0]; pre_ov = ov_s[0]; pre_pr = pr_s[0];
        for (int c = 0; c < 40 && got.size() < 2; c++) begin
            @(posedge clk); #1;
            if (pre_ov && ordy_s[0]) got.push_back(pre_pr);
            if (pre_ir && iv_s[0]) begin
                accepts++;
                if (accepts == 1) begin
                    a_s[0] = 4'd9; b_s[0] = 4'd5;
                end else begin
                    iv_s[0] = 1'b0;
                end
            end
            pre_ir = ir_s[0]; pre_ov = ov_s[0]; pre_pr = pr_s[0];
        end
        ordy_s[0] = 1'b0;
        iv_s[0]   = 1'b0;
        chk("b2b_results", got.size(), 2);
        chk("b2b_accepts", accepts, 2);
        if (got.size() == 2) begin
            chk("b2b_first_42", got[0], 8'd42);
            chk("b2b_second_45", got[1], 8'd45);
        end

        // Randomized operations against the arithmetic model.
        for (int r = 0; r < 30; r++) begin
            v.d    = int'($urandom_range(0, 2));
            v.a    = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            v.b    = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            v.hold = int'($urandom_range(0, 2));
            model(v.d, int'(v.a), int'(v.b), v.exp_p, v.exp_ovf, v.exp_lat);
            apply(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
